icache_data_ctrl: RTL and testbench

Initiator-side controller for the instruction-cache 64x128 single-port data SRAM (1RW, 64-bit write granularity). It sits between the I-cache fetch/refill logic and the SRAM macro. It arbitrates one SRAM access per cycle among flush sweeps, two-beat refill writes and line reads, and drives the macro's chip-select, write-enable, mask, address and data pins. It presents read data back through a valid/ready response port.

---
 rtl/icache_data_ctrl_pkg.sv | 60 ++++++
 rtl/icache_data_ctrl_if.sv | 53 +++++
 rtl/icache_data_ctrl.sv | 139 +++++++++++++
 tb/tb_icache_data_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_data_ctrl_pkg.sv
// Shared definitions for the I-cache data SRAM controller: FSM state
// encoding, array geometry, write-lane masks and the bundle of SRAM pin
// values that the controller grants for each cycle.
package icache_pkg;

   localparam int ICACHE_IDX_W      = 6;
   localparam int ICACHE_LINE_W     = 128;
   localparam int ICACHE_BEAT_W     = 64;
   localparam int ICACHE_NUM_WMASKS = 2;

   localparam logic [ICACHE_IDX_W-1:0] ICACHE_LAST_IDX = 6'd63;

   localparam logic [ICACHE_NUM_WMASKS-1:0] WM_NONE = 2'b00;
   localparam logic [ICACHE_NUM_WMASKS-1:0] WM_LO   = 2'b01;
   localparam logic [ICACHE_NUM_WMASKS-1:0] WM_HI   = 2'b10;
   localparam logic [ICACHE_NUM_WMASKS-1:0] WM_ALL  = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL_HI = 2'd1,
      FLUSH   = 2'd2
   } ctrl_state_e;

   typedef struct packed {
      logic                         csb;
      logic                         web;
      logic [ICACHE_NUM_WMASKS-1:0] wmask;
      logic [ICACHE_IDX_W-1:0]      addr;
      logic [ICACHE_LINE_W-1:0]     din;
   } sram_req_t;

   localparam sram_req_t SRAM_IDLE = '{
      csb:   1'b1,
      web:   1'b1,
      wmask: WM_NONE,
      addr:  '0,
      din:   '0
   };

   function automatic sram_req_t sram_wr(input logic [ICACHE_IDX_W-1:0]      idx,
                                         input logic [ICACHE_NUM_WMASKS-1:0] mask,
                                         input logic [ICACHE_LINE_W-1:0]     data);
      sram_req_t r;
      r.csb   = 1'b0;
      r.web   = 1'b0;
      r.wmask = mask;
      r.addr  = idx;
      r.din   = data;
      return r;
   endfunction

   function automatic sram_req_t sram_rd(input logic [ICACHE_IDX_W-1:0] idx);
      sram_req_t r;
      r      = SRAM_IDLE;
      r.csb  = 1'b0;
      r.addr = idx;
      return r;
   endfunction

endpackage

// File: rtl/icache_data_ctrl_if.sv
// Signal bundle between the I-cache fetch/refill logic, the data SRAM macro
// and the data controller.
//   read request  : rd_req_valid/rd_req_ready, rd_addr
//   read response : rd_resp_valid/rd_resp_ready, rd_resp_data
//   refill        : fill_valid/fill_ready, fill_addr, fill_data, fill_done
//   flush         : flush_req, flush_done
//   SRAM pins     : sram_csb, sram_web, sram_wmask, sram_addr, sram_din, sram_dout
// master = surroundings (fetch, refill, macro), slave = the controller.
interface icache_data_ctrl_if;
   import icache_pkg::*;

   logic                         rd_req_valid;
   logic                         rd_req_ready;
   logic [ICACHE_IDX_W-1:0]      rd_addr;
   logic                         rd_resp_valid;
   logic                         rd_resp_ready;
   logic [ICACHE_LINE_W-1:0]     rd_resp_data;

   logic                         fill_valid;
   logic                         fill_ready;
   logic [ICACHE_IDX_W-1:0]      fill_addr;
   logic [ICACHE_BEAT_W-1:0]     fill_data;
   logic                         fill_done;

   logic                         flush_req;
   logic                         flush_done;

   logic                         sram_csb;
   logic                         sram_web;
   logic [ICACHE_NUM_WMASKS-1:0] sram_wmask;
   logic [ICACHE_IDX_W-1:0]      sram_addr;
   logic [ICACHE_LINE_W-1:0]     sram_din;
   logic [ICACHE_LINE_W-1:0]     sram_dout;

   modport master (
      output rd_req_valid, rd_addr, rd_resp_ready,
      output fill_valid, fill_addr, fill_data,
      output flush_req, sram_dout,
      input  rd_req_ready, rd_resp_valid, rd_resp_data,
      input  fill_ready, fill_done, flush_done,
      input  sram_csb, sram_web, sram_wmask, sram_addr, sram_din
   );

   modport slave (
      input  rd_req_valid, rd_addr, rd_resp_ready,
      input  fill_valid, fill_addr, fill_data,
      input  flush_req, sram_dout,
      output rd_req_ready, rd_resp_valid, rd_resp_data,
      output fill_ready, fill_done, flush_done,
      output sram_csb, sram_web, sram_wmask, sram_addr, sram_din
   );

endinterface

// File: rtl/icache_data_ctrl.sv
// I-cache data SRAM controller. Grants one access per cycle to the 64x128
// single-port data array (flush sweep > refill beat > line read) and drives
// the macro pins combinationally from that grant.
// Ports: clk (also the macro clock), rst_aL (async, active-low),
//        bus (icache_data_ctrl_if.slave) carrying all handshakes and SRAM pins.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | accepting flush, refill beat 0 or a read
// FILL_HI | beat 0 written; waiting for beat 1, reads to other lines ok
// FLUSH   | zeroing lines 0..63, one per cycle; no fills or reads
module icache_data_ctrl
   import icache_pkg::*;
(
   input  logic              clk,
   input  logic              rst_aL,
   icache_data_ctrl_if.slave bus
);

   ctrl_state_e             state_q, state_d;
   logic [ICACHE_IDX_W-1:0] cnt_q, cnt_d;
   logic [ICACHE_IDX_W-1:0] fill_idx_q, fill_idx_d;
   logic                    resp_valid_q, resp_valid_d;
   logic                    fill_done_q, fill_done_d;
   logic                    flush_done_q, flush_done_d;

   logic                    slot_free;
   logic                    rd_acc;
   logic                    rd_req_ready;
   logic                    fill_ready;
   sram_req_t               sram;

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         fill_idx_q   <= '0;
         resp_valid_q <= 1'b0;
         fill_done_q  <= 1'b0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fill_idx_q   <= fill_idx_d;
         resp_valid_q <= resp_valid_d;
         fill_done_q  <= fill_done_d;
         flush_done_q <= flush_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fill_idx_d   = fill_idx_q;
      fill_done_d  = 1'b0;
      flush_done_d = 1'b0;
      rd_acc       = 1'b0;
      rd_req_ready = 1'b0;
      fill_ready   = 1'b0;
      sram         = SRAM_IDLE;

      // A new read may land while the old response is being taken this cycle.
      slot_free = !resp_valid_q || bus.rd_resp_ready;

      case (state_q)
         IDLE: begin
            if (bus.flush_req) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end else begin
               fill_ready   = 1'b1;
               // A presented refill beat takes the port, so a read cannot
               // be acknowledged in the same cycle.
               rd_req_ready = slot_free && !bus.fill_valid;
               if (bus.fill_valid) begin
                  sram       = sram_wr(bus.fill_addr, WM_LO,
                                       {{ICACHE_BEAT_W{1'b0}}, bus.fill_data});
                  fill_idx_d = bus.fill_addr;
                  state_d    = FILL_HI;
               end else if (bus.rd_req_valid && rd_req_ready) begin
                  sram   = sram_rd(bus.rd_addr);
                  rd_acc = 1'b1;
               end
            end
         end

         FILL_HI: begin
            fill_ready = 1'b1;
            if (bus.fill_valid) begin
               sram        = sram_wr(fill_idx_q, WM_HI,
                                     {bus.fill_data, {ICACHE_BEAT_W{1'b0}}});
               fill_done_d = 1'b1;
               state_d     = IDLE;
            end else begin
               // The half-written line must not be returned to fetch.
               rd_req_ready = slot_free && (bus.rd_addr != fill_idx_q);
               if (bus.rd_req_valid && rd_req_ready) begin
                  sram   = sram_rd(bus.rd_addr);
                  rd_acc = 1'b1;
               end
            end
         end

         FLUSH: begin
            sram  = sram_wr(cnt_q, WM_ALL, '0);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ICACHE_LAST_IDX) begin
               flush_done_d = 1'b1;
               state_d      = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      if (rd_acc) begin
         resp_valid_d = 1'b1;
      end else if (bus.rd_resp_ready) begin
         resp_valid_d = 1'b0;
      end else begin
         resp_valid_d = resp_valid_q;
      end
   end

   assign bus.rd_req_ready  = rd_req_ready;
   assign bus.fill_ready    = fill_ready;
   assign bus.rd_resp_valid = resp_valid_q;
   // The macro holds dout through writes and deselected cycles.
   assign bus.rd_resp_data  = bus.sram_dout;
   assign bus.fill_done     = fill_done_q;
   assign bus.flush_done    = flush_done_q;

   assign bus.sram_csb      = sram.csb;
   assign bus.sram_web      = sram.web;
   assign bus.sram_wmask    = sram.wmask;
   assign bus.sram_addr     = sram.addr;
   assign bus.sram_din      = sram.din;

endmodule

// File: tb/tb_icache_data_ctrl.sv
// Scoreboard bench for icache_data_ctrl: stimulus pushes the expected SRAM
// accesses and read responses; a monitor compares them as the DUT presents
// them. A behavioural 64x128 macro latches pins on posedge and acts on negedge.
module tb_icache_data_ctrl;
   import icache_pkg::*;

   typedef logic [139:0] v_t;

   typedef struct packed {
      logic         we;
      logic [5:0]   addr;
      logic [1:0]   mask;
      logic [127:0] din;
   } acc_t;

   logic clk;
   logic rst_aL;

   icache_data_ctrl_if bus ();

   icache_data_ctrl dut (
      .clk    (clk),
      .rst_aL (rst_aL),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   acc_t         acc_q[$];
   logic [127:0] resp_q[$];

   // ---------------- SRAM macro model ----------------
   logic [127:0] mem [64];
   logic [127:0] dout = '0;
   logic         l_csb = 1'b1;
   logic         l_web = 1'b1;
   logic [1:0]   l_mask = '0;
   logic [5:0]   l_addr = '0;
   logic [127:0] l_din = '0;

   initial for (int i = 0; i < 64; i++) mem[i] = '0;

   assign bus.sram_dout = dout;

   always @(posedge clk) begin
      l_csb  <= bus.sram_csb;
      l_web  <= bus.sram_web;
      l_mask <= bus.sram_wmask;
      l_addr <= bus.sram_addr;
      l_din  <= bus.sram_din;
   end

   always @(negedge clk) begin
      if (!l_csb) begin
         if (!l_web) begin
            if (l_mask[0]) mem[l_addr][63:0]   <= l_din[63:0];
            if (l_mask[1]) mem[l_addr][127:64] <= l_din[127:64];
         end else begin
            dout <= mem[l_addr];
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input v_t act, input v_t exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: actual %0h required %0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_wr(input logic [5:0] a, input logic [1:0] m, input logic [127:0] d);
      acc_t e;
      e.we = 1'b1; e.addr = a; e.mask = m; e.din = d;
      acc_q.push_back(e);
   endtask

   task automatic exp_rd(input logic [5:0] a, input logic [127:0] d);
      acc_t e;
      e.we = 1'b0; e.addr = a; e.mask = '0; e.din = '0;
      acc_q.push_back(e);
      resp_q.push_back(d);
   endtask

   // ---------------- monitor ----------------
   initial begin
      acc_t         e;
      logic [127:0] r;
      forever begin
         @(negedge clk);
         #1;
         if (!bus.sram_csb) begin
            if (acc_q.size() == 0) begin
               n_chk++;
               $display("FAIL sram_unexpected_access: actual web=%0b addr=%0d required no access",
                        bus.sram_web, bus.sram_addr);
            end else begin
               e = acc_q.pop_front();
               if (e.we)
                  chk("sram_write", v_t'({bus.sram_web, bus.sram_addr, bus.sram_wmask, bus.sram_din}),
                      v_t'({1'b0, e.addr, e.mask, e.din}));
               else
                  chk("sram_read", v_t'({bus.sram_web, bus.sram_addr}), v_t'({1'b1, e.addr}));
            end
         end else begin
            chk("sram_idle_pins", v_t'({bus.sram_web, bus.sram_wmask, bus.sram_addr, bus.sram_din}),
                v_t'({1'b1, 2'b00, 6'd0, 128'd0}));
         end
         if (bus.rd_resp_valid && bus.rd_resp_ready) begin
            if (resp_q.size() == 0) begin
               n_chk++;
               $display("FAIL rd_resp_unexpected: actual data %0h required no response", bus.rd_resp_data);
            end else begin
               r = resp_q.pop_front();
               chk("rd_resp_data", v_t'(bus.rd_resp_data), v_t'(r));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   localparam logic [127:0] LINE9  = 128'h3333_4444_5555_6666_AAAA_0000_1111_2222;
   localparam logic [127:0] LINE10 = 128'hCAFE_F00D_0000_0002_DEAD_BEEF_0000_0001;

   initial begin
      int n_pulse;
      rst_aL            = 1'b1;
      bus.rd_req_valid  = 1'b0;
      bus.rd_addr       = '0;
      bus.rd_resp_ready = 1'b1;
      bus.fill_valid    = 1'b0;
      bus.fill_addr     = '0;
      bus.fill_data     = '0;
      bus.flush_req     = 1'b0;
      #1 rst_aL = 1'b0;
      #1;
      chk("reset_sram_csb_web", v_t'({bus.sram_csb, bus.sram_web}), v_t'(2'b11));
      chk("reset_status", v_t'({bus.rd_resp_valid, bus.fill_done, bus.flush_done}), v_t'(3'b000));
      chk("reset_readies", v_t'({bus.rd_req_ready, bus.fill_ready}), v_t'(2'b11));
      tick();
      tick();
      rst_aL = 1'b1;
      tick();

      // Read of an unwritten line returns zero one cycle after acceptance.
      bus.rd_req_valid = 1'b1; bus.rd_addr = 6'd5;
      exp_rd(6'd5, '0);
      #1 chk("rd5_pins", v_t'({bus.rd_req_ready, bus.sram_csb, bus.sram_web, bus.sram_addr}),
             v_t'({1'b1, 1'b0, 1'b1, 6'd5}));
      tick();
      bus.rd_req_valid = 1'b0;
      #1 chk("rd5_resp_valid", v_t'(bus.rd_resp_valid), v_t'(1'b1));
      tick();
      #1 chk("rd5_resp_taken", v_t'(bus.rd_resp_valid), v_t'(1'b0));

      // Two-beat refill of line 9; beat-1 address is ignored.
      bus.fill_valid = 1'b1; bus.fill_addr = 6'd9; bus.fill_data = 64'hAAAA_0000_1111_2222;
      exp_wr(6'd9, WM_LO, {64'd0, 64'hAAAA_0000_1111_2222});
      #1 chk("fill_ready_idle", v_t'(bus.fill_ready), v_t'(1'b1));
      tick();
      bus.fill_addr = 6'd7; bus.fill_data = 64'h3333_4444_5555_6666;
      exp_wr(6'd9, WM_HI, {64'h3333_4444_5555_6666, 64'd0});
      tick();
      bus.fill_valid = 1'b0;
      #1 chk("fill_done_pulse", v_t'(bus.fill_done), v_t'(1'b1));
      bus.rd_req_valid = 1'b1; bus.rd_addr = 6'd9;
      exp_rd(6'd9, LINE9);
      tick();
      bus.rd_req_valid = 1'b0;
      #1 chk("fill_done_single", v_t'(bus.fill_done), v_t'(1'b0));
      tick();

      // In FILL_HI a read of the pending line stalls, another line is granted.
      bus.fill_valid = 1'b1; bus.fill_addr = 6'd9; bus.fill_data = 64'h0123_4567_89AB_CDEF;
      exp_wr(6'd9, WM_LO, {64'd0, 64'h0123_4567_89AB_CDEF});
      tick();
      bus.fill_valid = 1'b0;
      bus.rd_req_valid = 1'b1; bus.rd_addr = 6'd9;
      #1 chk("fillhi_same_idx_stall", v_t'(bus.rd_req_ready), v_t'(1'b0));
      tick();
      bus.rd_addr = 6'd4;
      exp_rd(6'd4, '0);
      #1 chk("fillhi_other_idx_grant", v_t'(bus.rd_req_ready), v_t'(1'b1));
      tick();
      bus.rd_req_valid = 1'b0;
      bus.fill_valid = 1'b1; bus.fill_data = 64'hFEDC_BA98_7654_3210;
      exp_wr(6'd9, WM_HI, {64'hFEDC_BA98_7654_3210, 64'd0});
      tick();
      bus.fill_valid = 1'b0;
      #1 chk("fillhi_fill_done", v_t'(bus.fill_done), v_t'(1'b1));
      tick();

      // Fill lines 0..3, then a full flush.
      for (int i = 0; i < 4; i++) begin
         bus.fill_valid = 1'b1; bus.fill_addr = 6'(i); bus.fill_data = 64'h1000 + 64'(i);
         exp_wr(6'(i), WM_LO, {64'd0, 64'h1000 + 64'(i)});
         tick();
         bus.fill_data = 64'h2000 + 64'(i);
         exp_wr(6'(i), WM_HI, {64'h2000 + 64'(i), 64'd0});
         tick();
      end
      bus.fill_valid = 1'b0;
      bus.flush_req  = 1'b1;
      for (int i = 0; i < 64; i++) exp_wr(6'(i), WM_ALL, '0);
      #1 chk("flush_start_readies", v_t'({bus.fill_ready, bus.rd_req_ready}), v_t'(2'b00));
      tick();
      bus.flush_req = 1'b0;
      #1 chk("flush_readies", v_t'({bus.fill_ready, bus.rd_req_ready}), v_t'(2'b00));
      repeat (63) tick();
      chk("flush_done_early", v_t'({bus.flush_done, bus.sram_addr}), v_t'({1'b0, 6'd63}));
      tick();
      chk("flush_done_cycle65", v_t'(bus.flush_done), v_t'(1'b1));
      tick();
      chk("flush_done_single", v_t'(bus.flush_done), v_t'(1'b0));
      for (int i = 0; i < 4; i++) begin
         bus.rd_req_valid = 1'b1; bus.rd_addr = 6'(i);
         exp_rd(6'(i), '0);
         tick();
      end
      bus.rd_req_valid = 1'b0;
      tick();

      // Backpressured response held across a refill; second read waits.
      bus.fill_valid = 1'b1; bus.fill_addr = 6'd10; bus.fill_data = 64'hDEAD_BEEF_0000_0001;
      exp_wr(6'd10, WM_LO, {64'd0, 64'hDEAD_BEEF_0000_0001});
      tick();
      bus.fill_data = 64'hCAFE_F00D_0000_0002;
      exp_wr(6'd10, WM_HI, {64'hCAFE_F00D_0000_0002, 64'd0});
      tick();
      bus.fill_valid = 1'b0;
      bus.rd_resp_ready = 1'b0;
      bus.rd_req_valid = 1'b1; bus.rd_addr = 6'd10;
      exp_rd(6'd10, LINE10);
      #1 chk("bp_first_accept", v_t'(bus.rd_req_ready), v_t'(1'b1));
      tick();
      bus.rd_addr = 6'd5;
      #1 chk("bp_hold1", v_t'({bus.rd_resp_valid, bus.rd_req_ready}), v_t'(2'b10));
      tick();
      bus.fill_valid = 1'b1; bus.fill_addr = 6'd11; bus.fill_data = 64'h5;
      exp_wr(6'd11, WM_LO, {64'd0, 64'h5});
      #1 chk("bp_hold2", v_t'({bus.rd_resp_valid, bus.rd_req_ready}), v_t'(2'b10));
      tick();
      bus.fill_data = 64'h6;
      exp_wr(6'd11, WM_HI, {64'h6, 64'd0});
      #1 chk("bp_hold3", v_t'({bus.rd_resp_valid, bus.rd_req_ready}), v_t'(2'b10));
      tick();
      bus.fill_valid = 1'b0;
      bus.rd_resp_ready = 1'b1;
      exp_rd(6'd5, '0);
      #1 chk("bp_second_accept", v_t'(bus.rd_req_ready), v_t'(1'b1));
      tick();
      bus.rd_req_valid = 1'b0;
      #1 chk("bp_second_resp", v_t'(bus.rd_resp_valid), v_t'(1'b1));
      tick();

      // Pending response survives the flush; reset at counter 20 aborts it.
      bus.rd_resp_ready = 1'b0;
      bus.rd_req_valid = 1'b1; bus.rd_addr = 6'd10;
      begin
         acc_t e;
         e.we = 1'b0; e.addr = 6'd10; e.mask = '0; e.din = '0;
         acc_q.push_back(e);
      end
      tick();
      bus.rd_req_valid = 1'b0;
      bus.flush_req = 1'b1;
      for (int i = 0; i < 20; i++) exp_wr(6'(i), WM_ALL, '0);
      tick();
      bus.flush_req = 1'b0;
      repeat (20) tick();
      chk("abort_at_cnt20", v_t'({bus.sram_csb, bus.sram_web, bus.sram_addr}), v_t'({1'b0, 1'b0, 6'd20}));
      chk("flush_pending_resp", v_t'({bus.rd_resp_valid, bus.rd_resp_data}), v_t'({1'b1, LINE10}));
      rst_aL = 1'b0;
      #1;
      chk("abort_reset_pins", v_t'({bus.sram_csb, bus.sram_web, bus.sram_wmask, bus.sram_addr}),
          v_t'({1'b1, 1'b1, 2'b00, 6'd0}));
      chk("abort_reset_status", v_t'({bus.rd_resp_valid, bus.fill_done, bus.flush_done, bus.rd_req_ready}),
          v_t'(4'b0001));
      tick();
      tick();
      rst_aL = 1'b1;
      bus.rd_resp_ready = 1'b1;
      n_pulse = 0;
      repeat (70) begin
         tick();
         if (bus.flush_done) n_pulse++;
      end
      chk("abort_no_flush_done", v_t'(n_pulse), v_t'(0));
      chk("acc_queue_drained", v_t'(acc_q.size()), v_t'(0));
      chk("resp_queue_drained", v_t'(resp_q.size()), v_t'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
